// File: rtl/wc_pkg.sv
// Shared definitions for the Winograd F(6,4) tile sequencer.
//   WC_TAPS  filter taps of the core
//   WC_M     results produced per tile
//   WC_TILE  input samples per tile (WC_M + WC_TAPS - 1)
//   WC_OVL   samples shared between consecutive tiles
//   wc_state_e  sequencer states
//   lane_lsb()  LSB position of lane idx in an MSB-first packed bus
package wc_pkg;

  localparam int WC_TAPS = 4;
  localparam int WC_M    = 6;
  localparam int WC_TILE = WC_M + WC_TAPS - 1;
  localparam int WC_OVL  = WC_TAPS - 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } wc_state_e;

  // Lane 0 occupies the most significant field of the bus.
  function automatic int lane_lsb(input int idx, input int n_lanes, input int width);
    return (n_lanes - 1 - idx) * width;
  endfunction

endpackage

// File: rtl/wc_tile_seq.sv
// Stream-side driver/unloader for the 1-D Winograd F(6,4) core.
// Collects a serial sample stream into overlapping 9-sample tiles (stride 6,
// overlap 3), presents each tile on core_d_o, waits CORE_LAT cycles, captures
// the 6-lane core result and serialises it onto the output stream.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   s_valid_i / s_ready_o / s_data_i / s_last_i   input sample stream
//   core_d_o   tile to core, sample 0 in the MSB field
//   core_z_i   core result, result 0 in the MSB field
//   m_valid_o / m_ready_i / m_data_o / m_last_o   output result stream
//   tile_cnt_o completed-tile counter (only with WC_TILE_CNT_EN defined)
//
// Build option: define WC_TILE_CNT_EN to add the tile_cnt_o port.
//
// state | meaning
// FILL  | accepting samples into the window
// WAIT  | window stable on core_d_o, waiting for the core latency
// DRAIN | emitting the 6 captured results
module wc_tile_seq
  import wc_pkg::*;
#(
  parameter int W        = 10,
  parameter int ZW       = 10,
  parameter int CORE_LAT = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [W-1:0]          s_data_i,
  input  logic                  s_last_i,
  output logic [WC_TILE*W-1:0]  core_d_o,
  input  logic [WC_M*ZW-1:0]    core_z_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ZW-1:0]         m_data_o,
  output logic                  m_last_o
`ifdef WC_TILE_CNT_EN
  ,
  output logic [15:0]           tile_cnt_o
`endif
);

  localparam int            LW       = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(CORE_LAT - 1);
  localparam logic [3:0]    CNT_FULL = 4'(WC_TILE);
  localparam logic [3:0]    CNT_LAST = 4'(WC_TILE - 1);
  localparam logic [3:0]    CNT_OVL  = 4'(WC_OVL);
  localparam logic [2:0]    K_LAST   = 3'(WC_M - 1);

  wc_state_e     state_q, state_d;
  logic [W-1:0]  win_q [WC_TILE];
  logic [W-1:0]  win_d [WC_TILE];
  logic [ZW-1:0] res_q [WC_M];
  logic [ZW-1:0] res_d [WC_M];
  logic [3:0]    cnt_q, cnt_d;
  logic          last_pend_q, last_pend_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [2:0]    k_q, k_d;
  logic [2:0]    k_nxt;
  logic          m_valid_q, m_valid_d;
  logic [ZW-1:0] m_data_q, m_data_d;
  logic          m_last_q, m_last_d;

  assign s_ready_o = (state_q == FILL) && !rst_i;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign k_nxt     = k_q + 3'd1;

  for (genvar gi = 0; gi < WC_TILE; gi++) begin : g_pack
    assign core_d_o[lane_lsb(gi, WC_TILE, W) +: W] = win_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_pend_d = last_pend_q;
    lat_d       = lat_q;
    k_d         = k_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    for (int i = 0; i < WC_TILE; i++) win_d[i] = win_q[i];
    for (int j = 0; j < WC_M; j++) res_d[j] = res_q[j];

    case (state_q)
      FILL: begin
        if (s_valid_i) begin
          // Lanes above the current one are zero-padded when the stream ends early.
          for (int i = 0; i < WC_TILE; i++) begin
            if (4'(i) == cnt_q) begin
              win_d[i] = s_data_i;
            end else if (s_last_i && (4'(i) > cnt_q)) begin
              win_d[i] = '0;
            end
          end
          cnt_d = cnt_q + 4'd1;
          if (s_last_i) begin
            last_pend_d = 1'b1;
            cnt_d       = CNT_FULL;
            lat_d       = '0;
            state_d     = WAIT;
          end else if (cnt_q == CNT_LAST) begin
            lat_d   = '0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (lat_q == LAT_LAST) begin
          for (int j = 0; j < WC_M; j++) begin
            res_d[j] = core_z_i[lane_lsb(j, WC_M, ZW) +: ZW];
          end
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      DRAIN: begin
        if (!m_valid_q) begin
          // First DRAIN cycle: load lane 0 into the output register.
          m_valid_d = 1'b1;
          m_data_d  = res_q[k_q];
          m_last_d  = last_pend_q && (k_q == K_LAST);
        end else if (m_ready_i) begin
          if (k_q == K_LAST) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = FILL;
            if (last_pend_q) begin
              for (int i = 0; i < WC_TILE; i++) win_d[i] = '0;
              cnt_d       = '0;
              last_pend_d = 1'b0;
            end else begin
              for (int i = 0; i < WC_OVL; i++) win_d[i] = win_q[WC_TILE - WC_OVL + i];
              cnt_d = CNT_OVL;
            end
          end else begin
            k_d      = k_nxt;
            m_data_d = res_q[k_nxt];
            m_last_d = last_pend_q && (k_nxt == K_LAST);
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
      lat_q       <= '0;
      k_q         <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      for (int i = 0; i < WC_TILE; i++) win_q[i] <= '0;
      for (int j = 0; j < WC_M; j++) res_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
      lat_q       <= lat_d;
      k_q         <= k_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      for (int i = 0; i < WC_TILE; i++) win_q[i] <= win_d[i];
      for (int j = 0; j < WC_M; j++) res_q[j] <= res_d[j];
    end
  end

`ifdef WC_TILE_CNT_EN
  logic        tile_done;
  logic [15:0] tile_cnt_q;

  assign tile_done  = (state_q == DRAIN) && m_valid_q && m_ready_i && (k_q == K_LAST);
  assign tile_cnt_o = tile_cnt_q;

  // Survives stream boundaries; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tile_cnt_q <= '0;
    end else if (tile_done) begin
      tile_cnt_q <= tile_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wc_tile_seq.sv
// Testbench for wc_tile_seq. The stub core applies a fixed lane function to
// core_d through a (CORE_LAT-1)-stage pipeline, so a capture made too early
// sees a stale tile. Expected tiles are built directly from the sample list:
// tile t covers samples 6t..6t+8, zero beyond the end of the stream.
module tb_wc_tile_seq;

  localparam int W        = 10;
  localparam int ZW       = 10;
  localparam int CORE_LAT = 6;
  localparam int PIPE     = CORE_LAT - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic [89:0]   core_d;
  logic [59:0]   core_z;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [ZW-1:0] m_data;
  logic          m_last;
`ifdef WC_TILE_CNT_EN
  logic [15:0]   tile_cnt;
`endif

  wc_tile_seq #(.W(W), .ZW(ZW), .CORE_LAT(CORE_LAT)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .core_d_o  (core_d),
    .core_z_i  (core_z),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last)
`ifdef WC_TILE_CNT_EN
    ,
    .tile_cnt_o(tile_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int tiles_done = 0;
  bit stub_mode = 1'b0;
  logic [89:0] obs_core_d;
  logic [W-1:0] smp [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: lane j = d[j] + (d[j+3] ^ d[j+1]) + (j+1), all mod 2^10.
  function automatic logic [59:0] fz(input logic [89:0] d);
    logic [59:0] z;
    logic [9:0] a, b, c;
    z = '0;
    for (int j = 0; j < 6; j++) begin
      a = d[(8 - j) * 10 +: 10];
      b = d[(5 - j) * 10 +: 10];
      c = d[(7 - j) * 10 +: 10];
      z[(5 - j) * 10 +: 10] = a + (b ^ c) + 10'(j + 1);
    end
    return z;
  endfunction

  logic [59:0] zpipe [PIPE];
  always @(posedge clk) begin
    zpipe[0] <= fz(core_d);
    for (int i = 1; i < PIPE; i++) zpipe[i] <= zpipe[i - 1];
  end
  assign core_z = stub_mode ? zpipe[PIPE - 1]
                            : {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};

  task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_core_d", core_d, 0);
`ifdef WC_TILE_CNT_EN
    check("rst_tile_cnt", tile_cnt, 0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    tiles_done = 0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input bit gaps);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("s_ready_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic recv_tile(input logic [89:0] tile, input bit last_tile, input int rmode);
    logic [59:0] z;
    int n, k, stall;
    bit seen, r;
    z = stub_mode ? fz(tile) : {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      if (m_valid) seen = 1;
      else begin
        check("s_ready_in_wait", s_ready, 0);
        n++;
      end
    end
    check("latency", 90'(cyc - hs_cyc), 90'(CORE_LAT + 1));
    if (!seen) return;
    obs_core_d = core_d;
    check("core_d", core_d, tile);
    k = 0; stall = 0; n = 0;
    while (k < 6 && n < 300) begin
      check("m_valid", m_valid, 1);
      check("m_data", m_data, z[(5 - k) * 10 +: 10]);
      check("m_last", m_last, (last_tile && k == 5) ? 1 : 0);
      check("s_ready_in_drain", s_ready, 0);
      case (rmode)
        0: r = 1;
        1: r = ($urandom_range(0, 2) != 0);
        default: begin
          if (k == 2 && stall < 3) begin
            r = 0; stall++;
          end else r = 1;
        end
      endcase
      m_ready = r;
      @(negedge clk);
      if (r) k++;
      n++;
    end
    m_ready = 1'b0;
    check("drain_done", 90'(k), 90'd6);
    check("m_valid_after_tile", m_valid, 0);
    tiles_done++;
  endtask

  task automatic run_stream(input int len, input int rmode);
    int s0, e;
    logic [89:0] tile;
    bit last_tile;
    for (int t = 0; t < 20; t++) begin
      s0 = (t == 0) ? 0 : 6 * t + 3;
      e = (6 * t + 8 < len - 1) ? 6 * t + 8 : len - 1;
      for (int idx = s0; idx <= e; idx++) send(smp[idx], (idx == len - 1), (rmode != 0));
      tile = '0;
      for (int i = 0; i < 9; i++) begin
        if (6 * t + i < len) tile[(8 - i) * 10 +: 10] = smp[6 * t + i];
      end
      last_tile = (6 * t + 8 >= len - 1);
      recv_tile(tile, last_tile, rmode);
      if (last_tile) break;
    end
  endtask

  initial begin
    int vals [9];
    logic [89:0] lit;
    int len;
    vals = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
    lit = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101;

    do_reset();

    // Single full tile against the constant stub.
    stub_mode = 1'b0;
    for (int i = 0; i < 9; i++) smp[i] = 10'(vals[i]);
    run_stream(9, 0);
    check("single_tile_core_d", obs_core_d, lit);

    // Overlapping tiles 1..9 and 7..15.
    stub_mode = 1'b1;
    for (int i = 0; i < 15; i++) smp[i] = 10'(i + 1);
    run_stream(15, 1);
    check("overlap_tile2_lanes012", obs_core_d[89:60], {10'd7, 10'd8, 10'd9});

    // Short stream padded with zeros.
    for (int i = 0; i < 5; i++) smp[i] = 10'($urandom_range(1, 1023));
    run_stream(5, 0);
    check("pad_lanes_5_8", obs_core_d[39:0], 40'd0);

    // Backpressure at lane 2.
    for (int i = 0; i < 9; i++) smp[i] = 10'($urandom_range(0, 1023));
    run_stream(9, 2);

    // s_last on the first sample.
    smp[0] = 10'($urandom_range(1, 1023));
    run_stream(1, 1);

    // Reset while the tile is waiting on the core.
    for (int i = 0; i < 9; i++) send(10'($urandom_range(0, 1023)), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_wait_s_ready", s_ready, 0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("aborted_tile_m_valid", m_valid, 0);
    end
    for (int i = 0; i < 9; i++) smp[i] = 10'($urandom_range(0, 1023));
    run_stream(9, 1);

    // Random streams.
    for (int s = 0; s < 10; s++) begin
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) smp[i] = 10'($urandom_range(0, 1023));
      run_stream(len, $urandom_range(0, 2));
    end

`ifdef WC_TILE_CNT_EN
    @(negedge clk);
    check("tile_cnt", tile_cnt, 90'(tiles_done));
    do_reset();
    for (int s = 0; s < 2; s++) begin
      len = (s == 0) ? 15 : 7;
      for (int i = 0; i < len; i++) smp[i] = 10'($urandom_range(0, 1023));
      run_stream(len, 1);
    end
    @(negedge clk);
    check("tile_cnt_three", tile_cnt, 90'd3);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wc_tile_seq.md
Name: wc_tile_seq

Overview:
- Stream-side driver and unloader for the 1-D Winograd F(6,4) core `WC`.
- Accepts a serial sample stream over valid/ready.
- Assembles overlapping 9-sample input tiles (stride 6, overlap 3) and presents each tile on the core's D bus.
- Waits a fixed core latency, captures the core's 6-lane Z result and serialises it onto an output valid/ready stream.

Parameters:
- W, 10, input sample width (signed two's complement)
- ZW, 10, result lane width from core (signed)
- CORE_LAT, 6, clock cycles from a stable D to a valid Z in `WC`

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts s_data this cycle
- s_data  in  W  input sample
- s_last  in  1  final sample of stream; qualified by s_valid&&s_ready
- core_d  out  9*W  tile to `WC`.D; sample 0 in [9W-1:8W], sample 8 in [W-1:0]
- core_z  in  6*ZW  `WC`.Z; result 0 in [6ZW-1:5ZW]
- m_valid  out  1  output result valid
- m_ready  in  1  downstream accepts m_data
- m_data  out  ZW  result sample
- m_last  out  1  last result of the final tile of a stream

Behaviour:
- Reset (synchronous, rst=1 at clk edge) clears the following, mid-operation included; any in-flight tile is discarded:
  - state=FILL, window count=0, core_d=0, s_ready=0 during rst and 1 the following cycle
  - m_valid=0, m_data=0, m_last=0, last_pending=0
- Window register holds 9 lanes; core_d is driven directly from it and is stable outside FILL.
- FILL:
  - s_ready=1. Each handshake writes s_data into lane `cnt`, then cnt++.
  - The first tile of a stream needs 9 samples (cnt 0→9). Later tiles need 6 new samples (cnt 3→9).
  - s_last handshake: set last_pending; the remaining lanes up to 8 are filled with 0 in the same cycle; go to WAIT.
  - s_last exactly on lane 8: no padding.
  - s_last on the first sample of a stream: lanes 1..8 become 0.
  - Go to WAIT when cnt reaches 9.
- WAIT:
  - s_ready=0. Latency counter runs 0..CORE_LAT-1.
  - On the cycle the counter equals CORE_LAT-1: capture core_z into a 6-lane result register, go to DRAIN.
- DRAIN:
  - m_valid=1; m_data = result lane k, k=0..5 in order (lane 0 is the MSB field).
  - k advances only on m_valid&&m_ready; m_valid/m_data hold under backpressure.
  - m_last=1 on k=5 only when last_pending.
  - After the k=5 handshake:
    - If last_pending: clear the window to 0, cnt=0, last_pending=0.
    - Else: lanes 6,7,8 shift to lanes 0,1,2 and cnt=3.
    - Return to FILL.
- Tile latency: the last input handshake to the first m_valid is CORE_LAT+1 cycles.
- Flow: no fill/drain overlap; s_ready is 0 throughout WAIT and DRAIN.
- Arithmetic: none; samples and results are passed bit-exact.

Optional Feature:
- Macro WC_TILE_CNT_EN.
- Defined: adds output port tile_cnt [15:0].
  - Counts completed tiles (k=5 handshake), wraps at 65535→0.
  - Cleared by rst; not cleared by stream end.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package wc_pkg holds:
  - constants WC_TAPS=4, WC_M=6, WC_TILE=9, WC_OVL=3
  - state enum {FILL, WAIT, DRAIN}
  - lane-slice helper macros or functions for MSB-first packing
- No sub-module; single FSM plus counters.

Test Plan:
- Single full tile:
  - Stimulus: stream 2,-10,3,4,-13,-18,-16,-28,-11 with s_last on -11.
  - Required response: core_d = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101, stable for CORE_LAT cycles.
  - Stub core returns Z lanes 1..6 → m_data 1,2,3,4,5,6 in order, m_last on 6.
- Overlap:
  - Stimulus: stream samples 1..15, s_last on 15.
  - Tile1 = 1..9.
  - Tile2 = 7..15; core_d lanes 0..2 = 7,8,9.
  - 12 outputs total, m_last only on the 12th.
- Padding:
  - Stimulus: stream 5 samples, s_last on the 5th.
  - core_d lanes 5..8 = 0; one tile; m_last on the 6th output.
- Backpressure:
  - Stimulus: m_ready low 3 cycles during DRAIN at k=2.
  - Required response: m_data stays lane 2, m_valid stays 1; the sequence resumes unchanged.
  - s_ready=0 throughout.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle in WAIT.
  - Required response: m_valid never rises for that tile; next cycle FILL, cnt=0, core_d=0.
  - A fresh 9-sample stream then completes normally.
- WC_TILE_CNT_EN:
  - Stimulus: two streams totalling 3 tiles.
  - Required response: tile_cnt=3; after rst, tile_cnt=0.
